// File: rtl/weapon_pkg.sv
// Shared definitions for the weapon arsenal controller.
//   - One-hot state encodings (bit0 = LOADED ... bit5 = RELOAD)
//   - State bit index constants for decoding individual states
//   - Width helpers used to size selector and timer fields
package weapon_pkg;

  localparam int ST_LOADED   = 0;
  localparam int ST_FIRING   = 1;
  localparam int ST_COOLDOWN = 2;
  localparam int ST_HOLD     = 3;
  localparam int ST_EMPTY    = 4;
  localparam int ST_RELOAD   = 5;

  localparam logic [5:0] S_LOADED   = 6'b000001;
  localparam logic [5:0] S_FIRING   = 6'b000010;
  localparam logic [5:0] S_COOLDOWN = 6'b000100;
  localparam logic [5:0] S_HOLD     = 6'b001000;
  localparam logic [5:0] S_EMPTY    = 6'b010000;
  localparam logic [5:0] S_RELOAD   = 6'b100000;

  // Selector width; a single weapon still needs one bit of index.
  function automatic int sel_width(input int n);
    int w;
    w = $clog2(n);
    return (w < 1) ? 1 : w;
  endfunction

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/weapon_timer.sv
// Loadable down-counter shared by the COOLDOWN and RELOAD phases.
//   clk, rst     : clock, asynchronous active-high reset
//   i_load       : load i_load_val this edge (the first counted cycle follows)
//   i_load_val   : number of cycles to count
//   o_done       : high during the last counted cycle
module weapon_timer #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_load,
  input  logic [W-1:0] i_load_val,
  output logic         o_done
);

  logic [W-1:0] r_count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= i_load_val;
    end else if (r_count != '0) begin
      r_count <= r_count - W'(1);
    end
  end

  // Done on the final cycle so the owning state lasts exactly load_val cycles.
  assign o_done = (r_count == W'(1));

endmodule

// File: rtl/weapon_arsenal_ctrl.sv
// Multi-weapon fire controller: per-weapon ammo, post-shot cooldown,
// timed reload and semi/auto fire modes.
//   clk, rst          : clock, asynchronous active-high reset
//   i_trigger         : fire button level (debounced)
//   i_reload_req      : reload request level
//   i_sel_req/i_sel_idx : weapon change pulse and requested index
//   o_fire_pulse      : one cycle per shot
//   o_weapon_state    : one-hot {RELOAD,EMPTY,HOLD,COOLDOWN,FIRING,LOADED}
//   o_active_weapon   : selected weapon
//   o_ammo            : ammo of the selected weapon
module weapon_arsenal_ctrl
  import weapon_pkg::*;
#(
  parameter int                     NUM_WEAPONS = 4,
  parameter int                     AMMO_W      = 8,
  parameter int                     MAX_AMMO    = 50,
  parameter int                     COOLDOWN    = 5_000_000,
  parameter int                     RELOAD_CYC  = 100_000_000,
  parameter logic [NUM_WEAPONS-1:0] AUTO_MASK   = NUM_WEAPONS'(4'b0010),
  localparam int                    SEL_W       = sel_width(NUM_WEAPONS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_trigger,
  input  logic              i_reload_req,
  input  logic              i_sel_req,
  input  logic [SEL_W-1:0]  i_sel_idx,
  output logic              o_fire_pulse,
  output logic [5:0]        o_weapon_state,
  output logic [SEL_W-1:0]  o_active_weapon,
  output logic [AMMO_W-1:0] o_ammo
);

  localparam int TMR_W = $clog2(max_int(COOLDOWN, RELOAD_CYC) + 1);
  localparam logic [AMMO_W-1:0] AMMO_FULL = AMMO_W'(MAX_AMMO);

  logic [5:0]        r_state;
  logic [SEL_W-1:0]  r_active;
  logic [AMMO_W-1:0] r_ammo [NUM_WEAPONS];

  logic [5:0]        w_state_next;
  logic [SEL_W-1:0]  w_active_next;
  logic              w_dec;
  logic              w_refill;
  logic              w_tmr_load;
  logic [TMR_W-1:0]  w_tmr_val;
  logic              w_tmr_done;
  logic              w_switch;
  logic              w_can_reload;
  logic [AMMO_W-1:0] w_cur_ammo;
  logic [AMMO_W-1:0] w_sel_ammo;

  assign w_cur_ammo   = r_ammo[r_active];
  assign w_sel_ammo   = r_ammo[i_sel_idx];
  assign w_switch     = i_sel_req && (32'(i_sel_idx) < 32'(NUM_WEAPONS)) &&
                        (i_sel_idx != r_active);
  assign w_can_reload = i_reload_req && (w_cur_ammo < AMMO_FULL);

  // State a weapon settles into when it becomes idle.
  function automatic logic [5:0] land(input logic [AMMO_W-1:0] a, input logic trig);
    if (a == '0)
      return S_EMPTY;
    else if (trig)
      return S_HOLD;
    else
      return S_LOADED;
  endfunction

  always_comb begin
    w_state_next  = r_state;
    w_active_next = r_active;
    w_dec         = 1'b0;
    w_refill      = 1'b0;
    w_tmr_load    = 1'b0;
    w_tmr_val     = '0;
    case (r_state)
      S_LOADED: begin
        if (w_switch) begin
          w_active_next = i_sel_idx;
          w_state_next  = land(w_sel_ammo, i_trigger);
        end else if (w_can_reload) begin
          w_state_next = S_RELOAD;
          w_tmr_load   = 1'b1;
          w_tmr_val    = TMR_W'(RELOAD_CYC);
        end else if (i_trigger) begin
          w_state_next = S_FIRING;
        end
      end
      S_FIRING: begin
        w_dec        = 1'b1;
        w_state_next = S_COOLDOWN;
        w_tmr_load   = 1'b1;
        w_tmr_val    = TMR_W'(COOLDOWN);
      end
      S_COOLDOWN: begin
        // Ammo was already decremented when FIRING exited.
        if (w_tmr_done) begin
          if (w_cur_ammo == '0)
            w_state_next = S_EMPTY;
          else if (i_trigger && AUTO_MASK[r_active])
            w_state_next = S_FIRING;
          else
            w_state_next = land(w_cur_ammo, i_trigger);
        end
      end
      S_HOLD: begin
        if (w_switch) begin
          w_active_next = i_sel_idx;
          w_state_next  = land(w_sel_ammo, i_trigger);
        end else if (w_can_reload) begin
          w_state_next = S_RELOAD;
          w_tmr_load   = 1'b1;
          w_tmr_val    = TMR_W'(RELOAD_CYC);
        end else if (!i_trigger) begin
          w_state_next = S_LOADED;
        end
      end
      S_EMPTY: begin
        if (w_switch) begin
          w_active_next = i_sel_idx;
          w_state_next  = land(w_sel_ammo, i_trigger);
        end else if (i_reload_req) begin
          w_state_next = S_RELOAD;
          w_tmr_load   = 1'b1;
          w_tmr_val    = TMR_W'(RELOAD_CYC);
        end
      end
      S_RELOAD: begin
        // Switching away abandons the reload; the old weapon keeps its ammo.
        if (w_switch) begin
          w_active_next = i_sel_idx;
          w_state_next  = land(w_sel_ammo, i_trigger);
        end else if (w_tmr_done) begin
          w_refill     = 1'b1;
          w_state_next = land(AMMO_FULL, i_trigger);
        end
      end
      default: w_state_next = S_LOADED;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= S_LOADED;
      r_active <= '0;
    end else begin
      r_state  <= w_state_next;
      r_active <= w_active_next;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_WEAPONS; i++)
        r_ammo[i] <= AMMO_FULL;
    end else begin
      for (int i = 0; i < NUM_WEAPONS; i++) begin
        if (r_active == SEL_W'(i)) begin
          if (w_refill)
            r_ammo[i] <= AMMO_FULL;
          else if (w_dec)
            r_ammo[i] <= r_ammo[i] - AMMO_W'(1);
        end
      end
    end
  end

  weapon_timer #(.W(TMR_W)) u_timer (
    .clk        (clk),
    .rst        (rst),
    .i_load     (w_tmr_load),
    .i_load_val (w_tmr_val),
    .o_done     (w_tmr_done)
  );

  assign o_weapon_state  = r_state;
  assign o_fire_pulse    = r_state[ST_FIRING];
  assign o_active_weapon = r_active;
  assign o_ammo          = w_cur_ammo;

endmodule

// File: tb/tb_weapon_arsenal_ctrl.sv
// Bench for weapon_arsenal_ctrl: per-cycle stimulus and expected outputs are
// queued together, then replayed and compared one cycle at a time.
module tb_weapon_arsenal_ctrl;

  localparam logic [5:0] LD = 6'b000001;
  localparam logic [5:0] FI = 6'b000010;
  localparam logic [5:0] CO = 6'b000100;
  localparam logic [5:0] HO = 6'b001000;
  localparam logic [5:0] EM = 6'b010000;
  localparam logic [5:0] RL = 6'b100000;

  logic       clk = 1'b0;
  logic       rst;
  logic       trig;
  logic       rreq;
  logic       sreq;
  logic [1:0] sidx;
  logic       fp;
  logic [5:0] st;
  logic [1:0] aw;
  logic [7:0] am;

  typedef struct packed {
    logic [5:0] st;
    logic       fp;
    logic [1:0] aw;
    logic [7:0] am;
  } exp_t;

  typedef struct packed {
    logic       trig;
    logic       rreq;
    logic       sreq;
    logic [1:0] sidx;
  } stim_t;

  exp_t  exp_q[$];
  stim_t stim_q[$];
  int    total = 0;
  int    bad   = 0;

  always #5 clk = ~clk;

  weapon_arsenal_ctrl #(
    .NUM_WEAPONS (4),
    .AMMO_W      (8),
    .MAX_AMMO    (3),
    .COOLDOWN    (3),
    .RELOAD_CYC  (8),
    .AUTO_MASK   (4'b0010)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .i_trigger       (trig),
    .i_reload_req    (rreq),
    .i_sel_req       (sreq),
    .i_sel_idx       (sidx),
    .o_fire_pulse    (fp),
    .o_weapon_state  (st),
    .o_active_weapon (aw),
    .o_ammo          (am)
  );

  always @(negedge clk)
    if (fp && !rst) $display("shot weapon=%0d ammo=%0d t=%0t", aw, am, $time);

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic exp_t sample();
    exp_t x;
    x.st = st; x.fp = fp; x.aw = aw; x.am = am;
    return x;
  endfunction

  function automatic exp_t mk(logic [5:0] s, logic f, logic [1:0] a, logic [7:0] m);
    exp_t x;
    x.st = s; x.fp = f; x.aw = a; x.am = m;
    return x;
  endfunction

  function automatic string fmt(exp_t x);
    return $sformatf("st=%b fp=%b aw=%0d am=%0d", x.st, x.fp, x.aw, x.am);
  endfunction

  // Queue one cycle: inputs to drive before the edge, outputs expected after it.
  task automatic plan(logic t, logic r, logic sr, logic [1:0] si,
                      logic [5:0] s, logic f, logic [1:0] a, logic [7:0] m);
    stim_t x;
    x.trig = t; x.rreq = r; x.sreq = sr; x.sidx = si;
    stim_q.push_back(x);
    exp_q.push_back(mk(s, f, a, m));
  endtask

  task automatic test_reset();
    exp_t o;
    rst = 1'b1; trig = 1'b0; rreq = 1'b0; sreq = 1'b0; sidx = 2'd0;
    #3;
    o = sample(); total++;
    if (o !== mk(LD, 0, 0, 3)) begin
      bad++; $display("FAIL reset_async got %s want %s", fmt(o), fmt(mk(LD, 0, 0, 3)));
    end
    repeat (2) tick();
    rst = 1'b0;
    tick();
    o = sample(); total++;
    if (o !== mk(LD, 0, 0, 3)) begin
      bad++; $display("FAIL reset_idle got %s want %s", fmt(o), fmt(mk(LD, 0, 0, 3)));
    end
  endtask

  task automatic test_semi_auto();
    stim_t s; exp_t e, o; int c = 0; int pc = 0;
    plan(1, 0, 0, 0, FI, 1, 0, 3);
    for (int i = 0; i < 3; i++)  plan(1, 0, 0, 0, CO, 0, 0, 2);
    for (int i = 0; i < 16; i++) plan(1, 0, 0, 0, HO, 0, 0, 2);
    plan(0, 0, 0, 0, LD, 0, 0, 2);
    while (stim_q.size() > 0) begin
      s = stim_q.pop_front();
      trig = s.trig; rreq = s.rreq; sreq = s.sreq; sidx = s.sidx;
      tick();
      e = exp_q.pop_front(); o = sample(); total++;
      if (o.fp) pc++;
      if (o !== e) begin
        bad++; $display("FAIL semi[%0d] got %s want %s", c, fmt(o), fmt(e));
      end
      c++;
    end
    total++;
    if (pc !== 1) begin
      bad++; $display("FAIL semi_pulses got %0d want 1", pc);
    end
  endtask

  task automatic test_auto_fire();
    stim_t s; exp_t e, o; int c = 0; int pulses[$];
    plan(0, 0, 1, 1, LD, 0, 1, 3);
    for (int k = 0; k < 3; k++) begin
      plan(1, 0, 0, 0, FI, 1, 1, 8'(3 - k));
      for (int i = 0; i < 3; i++) plan(1, 0, 0, 0, CO, 0, 1, 8'(2 - k));
    end
    for (int i = 0; i < 4; i++) plan(1, 0, 0, 0, EM, 0, 1, 0);
    while (stim_q.size() > 0) begin
      s = stim_q.pop_front();
      trig = s.trig; rreq = s.rreq; sreq = s.sreq; sidx = s.sidx;
      tick();
      e = exp_q.pop_front(); o = sample(); total++;
      if (o.fp) pulses.push_back(c);
      if (o !== e) begin
        bad++; $display("FAIL auto[%0d] got %s want %s", c, fmt(o), fmt(e));
      end
      c++;
    end
    total++;
    if (pulses.size() !== 3) begin
      bad++; $display("FAIL auto_pulses got %0d want 3", pulses.size());
    end
    for (int i = 1; i < pulses.size(); i++) begin
      total++;
      if (pulses[i] - pulses[i-1] !== 4) begin
        bad++; $display("FAIL auto_period got %0d want 4", pulses[i] - pulses[i-1]);
      end
    end
  endtask

  task automatic test_reload();
    stim_t s; exp_t e, o; int c = 0;
    plan(0, 0, 0, 0, EM, 0, 1, 0);
    plan(0, 1, 0, 0, RL, 0, 1, 0);
    for (int i = 0; i < 7; i++) plan(0, 0, 0, 0, RL, 0, 1, 0);
    plan(0, 0, 0, 0, LD, 0, 1, 3);
    while (stim_q.size() > 0) begin
      s = stim_q.pop_front();
      trig = s.trig; rreq = s.rreq; sreq = s.sreq; sidx = s.sidx;
      tick();
      e = exp_q.pop_front(); o = sample(); total++;
      if (o !== e) begin
        bad++; $display("FAIL reload[%0d] got %s want %s", c, fmt(o), fmt(e));
      end
      c++;
    end
  endtask

  task automatic test_switch_edges();
    stim_t s; exp_t e, o; int c = 0;
    // Switch during COOLDOWN is ignored.
    plan(0, 0, 1, 0, LD, 0, 0, 2);
    plan(1, 0, 0, 0, FI, 1, 0, 2);
    plan(0, 0, 0, 0, CO, 0, 0, 1);
    plan(0, 0, 1, 1, CO, 0, 0, 1);
    plan(0, 0, 0, 0, CO, 0, 0, 1);
    plan(0, 0, 0, 0, LD, 0, 0, 1);
    // Switch during RELOAD cancels it; weapon 0 keeps 1 round.
    plan(0, 1, 0, 0, RL, 0, 0, 1);
    plan(0, 0, 0, 0, RL, 0, 0, 1);
    plan(0, 0, 0, 0, RL, 0, 0, 1);
    plan(0, 0, 1, 1, LD, 0, 1, 3);
    plan(0, 0, 1, 0, LD, 0, 0, 1);
    // Empty weapon 0, then switching back to it lands in EMPTY.
    plan(1, 0, 0, 0, FI, 1, 0, 1);
    plan(0, 0, 0, 0, CO, 0, 0, 0);
    plan(0, 0, 0, 0, CO, 0, 0, 0);
    plan(0, 0, 0, 0, CO, 0, 0, 0);
    plan(0, 0, 0, 0, EM, 0, 0, 0);
    plan(0, 0, 1, 1, LD, 0, 1, 3);
    plan(0, 0, 1, 0, EM, 0, 0, 0);
    // Selecting the active weapon does nothing; trigger ignored when empty.
    plan(0, 0, 1, 0, EM, 0, 0, 0);
    plan(1, 0, 0, 0, EM, 0, 0, 0);
    // Reload with trigger held lands in HOLD.
    plan(1, 1, 0, 0, RL, 0, 0, 0);
    for (int i = 0; i < 7; i++) plan(1, 0, 0, 0, RL, 0, 0, 0);
    plan(1, 0, 0, 0, HO, 0, 0, 3);
    plan(0, 0, 0, 0, LD, 0, 0, 3);
    while (stim_q.size() > 0) begin
      s = stim_q.pop_front();
      trig = s.trig; rreq = s.rreq; sreq = s.sreq; sidx = s.sidx;
      tick();
      e = exp_q.pop_front(); o = sample(); total++;
      if (o !== e) begin
        bad++; $display("FAIL switch[%0d] got %s want %s", c, fmt(o), fmt(e));
      end
      c++;
    end
  endtask

  task automatic test_simultaneous();
    stim_t s; exp_t e, o; int c = 0;
    plan(1, 0, 1, 2, HO, 0, 2, 3);
    plan(1, 0, 0, 0, HO, 0, 2, 3);
    plan(0, 0, 0, 0, LD, 0, 2, 3);
    plan(0, 1, 0, 0, LD, 0, 2, 3);
    plan(0, 1, 0, 0, LD, 0, 2, 3);
    plan(0, 0, 0, 0, LD, 0, 2, 3);
    while (stim_q.size() > 0) begin
      s = stim_q.pop_front();
      trig = s.trig; rreq = s.rreq; sreq = s.sreq; sidx = s.sidx;
      tick();
      e = exp_q.pop_front(); o = sample(); total++;
      if (o !== e) begin
        bad++; $display("FAIL simul[%0d] got %s want %s", c, fmt(o), fmt(e));
      end
      c++;
    end
  endtask

  task automatic test_reset_mid();
    stim_t s; exp_t e, o; int c = 0;
    plan(1, 0, 0, 0, FI, 1, 2, 3);
    plan(0, 0, 0, 0, CO, 0, 2, 2);
    plan(0, 0, 0, 0, CO, 0, 2, 2);
    plan(0, 0, 0, 0, CO, 0, 2, 2);
    plan(0, 0, 0, 0, LD, 0, 2, 2);
    plan(0, 1, 0, 0, RL, 0, 2, 2);
    plan(0, 0, 0, 0, RL, 0, 2, 2);
    plan(0, 0, 0, 0, RL, 0, 2, 2);
    while (stim_q.size() > 0) begin
      s = stim_q.pop_front();
      trig = s.trig; rreq = s.rreq; sreq = s.sreq; sidx = s.sidx;
      tick();
      e = exp_q.pop_front(); o = sample(); total++;
      if (o !== e) begin
        bad++; $display("FAIL rstmid[%0d] got %s want %s", c, fmt(o), fmt(e));
      end
      c++;
    end
    // Asynchronous reset in the middle of RELOAD.
    #2 rst = 1'b1;
    #1 o = sample(); total++;
    if (o !== mk(LD, 0, 0, 3)) begin
      bad++; $display("FAIL rst_in_reload got %s want %s", fmt(o), fmt(mk(LD, 0, 0, 3)));
    end
    #2 rst = 1'b0;
    tick();
    o = sample(); total++;
    if (o !== mk(LD, 0, 0, 3)) begin
      bad++; $display("FAIL rst_reload_after got %s want %s", fmt(o), fmt(mk(LD, 0, 0, 3)));
    end
    // Weapon 2 was refilled by reset; then fire it and reset in FIRING.
    sreq = 1'b1; sidx = 2'd2;
    tick();
    sreq = 1'b0;
    o = sample(); total++;
    if (o !== mk(LD, 0, 2, 3)) begin
      bad++; $display("FAIL rst_refill_w2 got %s want %s", fmt(o), fmt(mk(LD, 0, 2, 3)));
    end
    trig = 1'b1;
    tick();
    trig = 1'b0;
    o = sample(); total++;
    if (o !== mk(FI, 1, 2, 3)) begin
      bad++; $display("FAIL pre_rst_fire got %s want %s", fmt(o), fmt(mk(FI, 1, 2, 3)));
    end
    #2 rst = 1'b1;
    #1 o = sample(); total++;
    if (o !== mk(LD, 0, 0, 3)) begin
      bad++; $display("FAIL rst_in_fire got %s want %s", fmt(o), fmt(mk(LD, 0, 0, 3)));
    end
    #2 rst = 1'b0;
    tick();
    sreq = 1'b1; sidx = 2'd2;
    tick();
    sreq = 1'b0;
    o = sample(); total++;
    if (o !== mk(LD, 0, 2, 3)) begin
      bad++; $display("FAIL rst_fire_w2 got %s want %s", fmt(o), fmt(mk(LD, 0, 2, 3)));
    end
  endtask

  initial begin
    test_reset();
    test_semi_auto();
    test_auto_fire();
    test_reload();
    test_switch_edges();
    test_simultaneous();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
